// File: rtl/effects_pkg.sv
// Shared definitions for the effects peripheral delay-RAM scheduler:
// RAM geometry, scheduler state encodings and status register layout.
package effects_pkg;

  localparam int unsigned RAM_AW   = 13;
  localparam int unsigned RAM_DW   = 8;
  localparam int unsigned STATUS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_CLEAR   = 2'd3
  } sched_state_t;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_LAST  = 1;
  localparam int unsigned STAT_EN_LO = 2;
  localparam int unsigned STAT_EN_HI = 3;
  localparam int unsigned STAT_CLR   = 4;

  // Assemble the status byte; unused bits stay 0.
  function automatic logic [STATUS_W-1:0] make_status(
    input logic       busy,
    input logic       last,
    input logic [1:0] en_m,
    input logic       clr
  );
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STAT_BUSY] = busy;
    s[STAT_LAST] = last;
    s[STAT_EN_HI:STAT_EN_LO] = en_m;
    s[STAT_CLR] = clr;
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter (combinational). On a tie the requester
// that did not win last is chosen; a lone eligible requester always wins.
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick the winner from the eligible set and the previous winner.
  always_comb begin
    gnt_valid = |eligible;
    gnt_idx   = 1'b0;
    case (eligible)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/delay_ram_scheduler.sv
// Time-multiplexes the shared dual-port delay RAM between the echo (0) and
// flanger (1) engines. Each access writes port A and reads port B; the read
// data returns to the owner with a one-cycle ack pulse, three cycles after
// grant. Optional build macro DELAY_RAM_CLEAR_EN adds clr_start and a
// CLEAR state that zero-fills the whole RAM.
module delay_ram_scheduler
  import effects_pkg::*;
#(
  parameter int unsigned AW   = RAM_AW,
  parameter int unsigned DW   = RAM_DW,
  parameter int unsigned NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef DELAY_RAM_CLEAR_EN
  input  logic               clr_start,
`endif
  input  logic [NREQ-1:0]    en,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we_req,
  input  logic [NREQ*AW-1:0] wadr_req,
  input  logic [NREQ*DW-1:0] wdat_req,
  input  logic [NREQ*AW-1:0] radr_req,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdat,
  output logic [AW-1:0]      adr_a,
  output logic [DW-1:0]      dat_a,
  output logic               we_a,
  output logic [AW-1:0]      adr_b,
  input  logic [DW-1:0]      dat_b,
  output logic [7:0]         status
);

  sched_state_t  state;
  logic          rr_ptr;    // requester preferred on the next tie
  logic          last_gnt;  // most recent completed grant, for status
  logic          owner;     // requester owning the in-flight access

  logic [1:0]    eligible;
  logic          gnt_valid;
  logic          gnt_idx;

  logic          sel_we;
  logic [AW-1:0] sel_wadr;
  logic [DW-1:0] sel_wdat;
  logic [AW-1:0] sel_radr;

  assign eligible = req & en;

  rr_arbiter2 u_arb (
    .eligible  (eligible),
    .last      (~rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Operand mux for the requester the arbiter currently selects.
  always_comb begin
    sel_we = we_req[gnt_idx];
    if (gnt_idx) begin
      sel_wadr = wadr_req[2*AW-1:AW];
      sel_wdat = wdat_req[2*DW-1:DW];
      sel_radr = radr_req[2*AW-1:AW];
    end else begin
      sel_wadr = wadr_req[AW-1:0];
      sel_wdat = wdat_req[DW-1:0];
      sel_radr = radr_req[AW-1:0];
    end
  end

  // Scheduler FSM with all RAM-side and requester-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      last_gnt <= 1'b0;
      owner    <= 1'b0;
      ack      <= '0;
      rdat     <= '0;
      adr_a    <= '0;
      dat_a    <= '0;
      we_a     <= 1'b0;
      adr_b    <= '0;
      status   <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
`ifdef DELAY_RAM_CLEAR_EN
          if (clr_start) begin
            adr_a  <= '0;
            dat_a  <= '0;
            we_a   <= 1'b1;
            state  <= ST_CLEAR;
            status <= make_status(1'b1, last_gnt, en, 1'b1);
          end else
`endif
          if (gnt_valid) begin
            owner  <= gnt_idx;
            adr_a  <= sel_wadr;
            dat_a  <= sel_wdat;
            we_a   <= sel_we;
            adr_b  <= sel_radr;
            state  <= ST_ACCESS;
            status <= make_status(1'b1, last_gnt, en, 1'b0);
          end else begin
            status <= make_status(1'b0, last_gnt, en, 1'b0);
          end
        end

        ST_ACCESS: begin
          we_a   <= 1'b0;
          state  <= ST_CAPTURE;
          status <= make_status(1'b1, last_gnt, en, 1'b0);
        end

        ST_CAPTURE: begin
          rdat     <= dat_b;
          ack      <= NREQ'(1) << owner;
          last_gnt <= owner;
          rr_ptr   <= ~owner;
          state    <= ST_IDLE;
          status   <= make_status(1'b0, owner, en, 1'b0);
        end

`ifdef DELAY_RAM_CLEAR_EN
        ST_CLEAR: begin
          if (adr_a == '1) begin
            we_a   <= 1'b0;
            state  <= ST_IDLE;
            status <= make_status(1'b0, last_gnt, en, 1'b0);
          end else begin
            adr_a  <= adr_a + AW'(1);
            status <= make_status(1'b1, last_gnt, en, 1'b1);
          end
        end
`endif

        default: begin
          we_a   <= 1'b0;
          state  <= ST_IDLE;
          status <= make_status(1'b0, last_gnt, en, 1'b0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_ram_scheduler.sv
// Bench for delay_ram_scheduler: a transaction-level model plus a RAM
// behavioural model, compared on every falling edge, and directed vectors
// with literal expectations.
module tb_delay_ram_scheduler;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    en, req, we;
  logic [AW-1:0] wadr0, wadr1, radr0, radr1;
  logic [DW-1:0] wdat0, wdat1;
  logic [1:0]    ack;
  logic [DW-1:0] rdat, dat_a, dat_b;
  logic [AW-1:0] adr_a, adr_b;
  logic          we_a;
  logic [7:0]    status;
`ifdef DELAY_RAM_CLEAR_EN
  logic          clr_start;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  delay_ram_scheduler dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DELAY_RAM_CLEAR_EN
    .clr_start(clr_start),
`endif
    .en       (en),
    .req      (req),
    .we_req   (we),
    .wadr_req ({wadr1, wadr0}),
    .wdat_req ({wdat1, wdat0}),
    .radr_req ({radr1, radr0}),
    .ack      (ack),
    .rdat     (rdat),
    .adr_a    (adr_a),
    .dat_a    (dat_a),
    .we_a     (we_a),
    .adr_b    (adr_b),
    .dat_b    (dat_b),
    .status   (status)
  );

  // Dual-port RAM, read-first, one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (we_a) ram[adr_a] <= dat_a;
    dat_b <= ram[adr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_cnt = 0;      // cycles remaining until the ack
  int            m_clr = 0;      // clear writes remaining
  bit            m_owner = 1'b0, m_pref = 1'b0, m_last = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic [1:0]    e_ack = '0;
  logic [DW-1:0] e_rdat = '0, e_dat_a = '0;
  logic [AW-1:0] e_adr_a = '0, e_adr_b = '0;
  logic          e_we = 1'b0;
  logic [7:0]    e_status = '0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    logic [1:0] elig;
    bit         w;
    if (rst) begin
      m_cnt = 0; m_clr = 0; m_pref = 1'b0; m_last = 1'b0; m_owner = 1'b0;
      e_ack = '0; e_rdat = '0; e_dat_a = '0; e_adr_a = '0; e_adr_b = '0;
      e_we = 1'b0; e_status = '0;
    end else begin
      e_ack = '0;
      elig  = req & en;
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) e_we = 1'b0;
        else e_adr_a = e_adr_a + 13'd1;
      end else if (m_cnt == 2) begin
        m_cnt = 1;
        e_we  = 1'b0;
      end else if (m_cnt == 1) begin
        m_cnt  = 0;
        e_ack  = (m_owner) ? 2'b10 : 2'b01;
        e_rdat = m_rd;
        m_last = m_owner;
        m_pref = !m_owner;
      end
`ifdef DELAY_RAM_CLEAR_EN
      else if (clr_start) begin
        m_clr   = 1 << AW;
        e_adr_a = '0;
        e_dat_a = '0;
        e_we    = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      end
`endif
      else if (elig != 2'b00) begin
        w       = (elig == 2'b11) ? m_pref : elig[1];
        m_owner = w;
        e_adr_a = w ? wadr1 : wadr0;
        e_dat_a = w ? wdat1 : wdat0;
        e_we    = we[w];
        e_adr_b = w ? radr1 : radr0;
        m_rd    = ref_mem[e_adr_b];
        if (e_we) ref_mem[e_adr_a] = e_dat_a;
        m_cnt   = 2;
      end
      e_status = {3'b000, (m_clr > 0), en, m_last, (m_cnt > 0 || m_clr > 0)};
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("ack",    32'(ack),    32'(e_ack));
      check("rdat",   32'(rdat),   32'(e_rdat));
      check("we_a",   32'(we_a),   32'(e_we));
      check("adr_a",  32'(adr_a),  32'(e_adr_a));
      check("dat_a",  32'(dat_a),  32'(e_dat_a));
      check("adr_b",  32'(adr_b),  32'(e_adr_b));
      check("status", 32'(status), 32'(e_status));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic [1:0] which, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack !== which && n < budget);
    check("ack_wait", 32'(ack), 32'(which));
  endtask

  initial begin
    int          n, cnt;
    logic [1:0]  seq[$];
    int          when[$];
    logic [AW-1:0] gadr[$];

    rst = 1'b1; en = '0; req = '0; we = '0;
    wadr0 = '0; wadr1 = '0; radr0 = '0; radr1 = '0; wdat0 = '0; wdat1 = '0;
`ifdef DELAY_RAM_CLEAR_EN
    clr_start = 1'b0;
`endif
    repeat (3) step();
    cmp_on = 1'b1;
    check("rst_ack",    32'(ack),    32'h0);
    check("rst_we_a",   32'(we_a),   32'h0);
    check("rst_adr_a",  32'(adr_a),  32'h0);
    check("rst_status", 32'(status), 32'h0);
    rst = 1'b0;

    // single write
    en = 2'b01; we = 2'b01; wadr0 = 13'h0100; wdat0 = 8'hA5; radr0 = 13'h0100; req = 2'b01;
    step();
    check("wr_adr_a", 32'(adr_a), 32'h0100);
    check("wr_dat_a", 32'(dat_a), 32'hA5);
    check("wr_we_hi", 32'(we_a),  32'h1);
    check("wr_busy",  32'(status[0]), 32'h1);
    step();
    check("wr_we_lo", 32'(we_a), 32'h0);
    step();
    check("wr_ack", 32'(ack), 32'h1);
    req = 2'b00;
    step();
    check("wr_ack_pulse", 32'(ack), 32'h0);

    // read-back
    we = 2'b00; req = 2'b01;
    wait_ack(2'b01, 10, n);
    check("rd_latency", 32'(n), 32'd3);
    check("rd_rdat", 32'(rdat), 32'hA5);
    req = 2'b00;

    // contention from reset: strict alternation starting with 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    en = 2'b11; we = 2'b11;
    wadr0 = 13'h0010; wdat0 = 8'h11; radr0 = 13'h0100;
    wadr1 = 13'h0020; wdat1 = 8'h22; radr1 = 13'h0010;
    req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      step();
      if (we_a) gadr.push_back(adr_a);
      if (ack != 2'b00) begin
        seq.push_back(ack);
        when.push_back(c);
      end
    end
    req = 2'b00;
    check("cont_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size() && i < 4; i++) begin
      check("cont_order", 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_when",  32'(when[i]), 32'(2 + 3 * i));
    end
    for (int i = 0; i < gadr.size() && i < 4; i++)
      check("cont_adr_a", 32'(gadr[i]), (i % 2 == 0) ? 32'h0010 : 32'h0020);

    // disable requester 1 while its access is in flight
    en = 2'b11; we = 2'b10; wadr1 = 13'h0020; wdat1 = 8'h5A; req = 2'b10;
    step();
    check("dis_adr_a", 32'(adr_a), 32'h0020);
    en = 2'b01;
    step();
    step();
    check("dis_ack", 32'(ack), 32'h2);
    cnt = 0;
    repeat (6) begin
      step();
      if (ack != 2'b00 || we_a) cnt++;
    end
    check("dis_no_regrant", 32'(cnt), 32'h0);
    check("dis_idle", 32'(status[0]), 32'h0);
    req = 2'b00;

    // reset during ACCESS of a write
    en = 2'b11; we = 2'b01; wadr0 = 13'h1FFF; wdat0 = 8'h3C; req = 2'b01;
    step();
    check("rstm_we_hi", 32'(we_a), 32'h1);
    rst = 1'b1;
    step();
    check("rstm_we_a",   32'(we_a),   32'h0);
    check("rstm_adr_a",  32'(adr_a),  32'h0);
    check("rstm_ack",    32'(ack),    32'h0);
    check("rstm_status", 32'(status), 32'h0);
    rst = 1'b0;
    wadr0 = 13'h00AA; wadr1 = 13'h00BB; we = 2'b11; req = 2'b11;
    step();
    check("rstm_regrant0", 32'(adr_a), 32'h00AA);
    step();
    step();
    check("rstm_ack0", 32'(ack), 32'h1);
    req = 2'b00;

`ifdef DELAY_RAM_CLEAR_EN
    // whole-RAM clear holds off a pending request
    en = 2'b01; we = 2'b00; radr0 = 13'h0100; req = 2'b01; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    check("clr_flag",  32'(status[4]), 32'h1);
    check("clr_first", 32'(adr_a), 32'h0);
    cnt = 1;
    n = 0;
    for (int k = 0; k < 9000; k++) begin
      step();
      if (ack != 2'b00) n++;
      if (!we_a) break;
      cnt++;
    end
    check("clr_writes", 32'(cnt), 32'd8192);
    check("clr_no_ack", 32'(n), 32'h0);
    wait_ack(2'b01, 10, n);
    check("clr_ack_latency", 32'(n), 32'd3);
    check("clr_rdat", 32'(rdat), 32'h0);
    req = 2'b00;
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_ram_scheduler.md
Name: delay_ram_scheduler

Overview:
- Time-multiplexes the shared 8K x 8 dual-port delay RAM between two effect engines (0 = echo, 1 = flanger) using per-requester req/ack handshakes.
- Each access is a write to port A plus a read from port B. Read data is returned to the owning engine.
- Sits between the effect engines and the delay RAM inside the effects Wishbone peripheral.
- Replaces static ownership selection, so both engines can run concurrently.

Parameters:
- AW, 13, RAM address width.
- DW, 8, RAM data width.
- NREQ, 2, number of requesters. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  2  per-requester enable from the effects config register
- req  in  2  access request, one bit per requester
- we_req  in  2  per-requester write enable for the access
- wadr_req  in  2*AW  per-requester port-A write address, packed, requester 0 in the LSBs
- wdat_req  in  2*DW  per-requester write data, packed
- radr_req  in  2*AW  per-requester port-B read address, packed
- ack  out  2  one-cycle pulse when the access completes
- rdat  out  DW  read data, valid while ack is high
- adr_a  out  AW  RAM port-A address
- dat_a  out  DW  RAM port-A data
- we_a  out  1  RAM port-A write enable
- adr_b  out  AW  RAM port-B address
- dat_b  in  DW  RAM port-B read data, one-cycle synchronous latency
- status  out  8  bit0 busy; bit1 last grant; bits3:2 enable mirror; bit4 clear active; other bits 0

Behaviour:
- Reset: clk and rst (synchronous, active-high) are as already decided. On reset all outputs go to 0, the FSM enters IDLE and the round-robin pointer resets to 0 (requester 0 wins the first tie).
- FSM states and transitions:
  - IDLE: eligible = req & en. If none are eligible, stay in IDLE.
  - IDLE grant rule: otherwise grant the eligible requester that is not the last winner. With a single eligible requester, grant it.
  - IDLE grant actions: register that requester's wadr, wdat, we and radr onto adr_a, dat_a, we_a and adr_b, then move to ACCESS.
  - ACCESS: the RAM samples the addresses this cycle. Drive we_a to 0 on the exiting edge, then move to CAPTURE.
  - CAPTURE: dat_b is valid. Register it into rdat, pulse ack[g], update the last winner to g, and return to IDLE.
- Timing:
  - Latency from the first IDLE cycle with req high to the ack pulse is 3 cycles.
  - we_a is high for exactly 1 cycle per write access.
  - Maximum throughput is one access per 3 cycles.
- Handshake rules:
  - A requester holds req and its operands stable until it sees ack.
  - A requester may drop req in the cycle after ack, or keep it high to issue back-to-back requests.
  - Operands are captured at grant, so changes after grant are ignored.
- Boundary conditions:
  - Simultaneous requests from both requesters: strict alternation.
  - A requester that keeps req high permanently cannot starve the other.
  - en bit cleared mid-transaction: the in-flight access completes and ack is still issued. No new grant follows.
  - req dropped before ack (protocol violation): the access still completes and the ack pulse is issued.
  - Reset mid-transaction: the access is aborted, no ack is issued and we_a is forced to 0 on the next edge.
  - Addresses pass through unchanged; wrap-around is the requester's responsibility.

Optional Feature:
- Macro: DELAY_RAM_CLEAR_EN.
- When defined:
  - Adds input clr_start (1 bit) and a CLEAR state.
  - A pulse of clr_start while in IDLE enters CLEAR, which writes 0 to every address from 0 to 2^AW-1, one per cycle, with we_a held high.
  - Requests are held off (no ack) while CLEAR runs. status bit4 is 1 during CLEAR.
  - After the final address, return to IDLE with we_a at 0.
  - clr_start outside IDLE is ignored.
- When undefined: no clr_start port, no CLEAR state, and status bit4 is tied to 0.

Decomposition:
- Shared package effects_pkg holds:
  - State encodings: ST_IDLE, ST_ACCESS, ST_CAPTURE, ST_CLEAR.
  - Status bit indices.
  - RAM_AW = 13 and RAM_DW = 8.
- One sub-module is natural: rr_arbiter2, which is combinational. Inputs are eligible[1:0] and last; outputs are gnt_valid and gnt_idx.

Test Plan:
- Single write: en=01, req0 with we=1, wadr=0x0100, wdat=0xA5, radr=0x0100 -> we_a pulses for 1 cycle with adr_a=0x0100 and dat_a=0xA5, and ack0 is asserted 3 cycles after req.
- Read-back: after the write above, req0 with we=0 and radr=0x0100 -> ack0 asserted with rdat=0xA5, and we_a stays 0.
- Contention: en=11, req0 and req1 held high for 12 cycles -> acks alternate 0,1,0,1 with 3-cycle spacing, and each port-A address matches its grantee.
- Disable mid-transaction: requester 1 is granted, then en[1] is cleared in ACCESS -> ack1 is still issued, and no further grant goes to requester 1.
- Reset during ACCESS with we=1 -> on the next edge all outputs are 0, no ack is issued, and the next request is granted to requester 0.
- With DELAY_RAM_CLEAR_EN: clr_start in IDLE -> 8192 consecutive writes of 0 (addresses 0 to 0x1FFF), req0 is stalled until CLEAR completes, then ack0 is issued 3 cycles later.
